mat_tile_cache: RTL and testbench

MAT_TILE_CACHE -- requirements
Module: mat_tile_cache

---
 rtl/mat_tile_cache.sv | 153 +++++++++++++++
 tb/tb_mat_tile_cache.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_tile_cache.sv
// Cache of CACHE_SIZE square matrix blocks with row/column/diagonal vector access.
// Optional in-cache transpose (COPY_T) is built only when MAT_CACHE_COPY_EN is defined.
module mat_tile_cache #(
  parameter int WIDTH      = 16,
  parameter int DATA_W     = 32,
  parameter int CACHE_SIZE = 4,
  localparam int AW = $clog2(CACHE_SIZE),
  localparam int PW = $clog2(WIDTH)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [AW-1:0]                 cmd_addr1,
  input  logic [AW-1:0]                 cmd_addr2,
  input  logic [PW-1:0]                 cmd_param,
  input  logic [WIDTH-1:0][DATA_W-1:0]  data_in,
  output logic [WIDTH-1:0][DATA_W-1:0]  data_out,
  output logic                          rd_valid,
  output logic                          busy,
  output logic                          done
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready and reset is low.
  localparam logic [2:0] OP_WRITE_ROW = 3'd1;
  localparam logic [2:0] OP_WRITE_COL = 3'd2;
  localparam logic [2:0] OP_WRITE_DIAG = 3'd3;
  localparam logic [2:0] OP_READ_ROW = 3'd4;
  localparam logic [2:0] OP_READ_COL = 3'd5;
  localparam logic [2:0] OP_READ_DIAG = 3'd6;

  logic [DATA_W-1:0]           r_blk [CACHE_SIZE][WIDTH][WIDTH];
  logic [WIDTH-1:0][DATA_W-1:0] r_data_out;
  logic                        r_rd_valid;
  logic                        w_accept;
  logic                        w_is_read;
  logic [AW-1:0]               w_dblk [WIDTH];
  logic [PW-1:0]               w_dcol [WIDTH];
  logic [WIDTH-1:0][DATA_W-1:0] w_rd_vec;

  assign w_accept  = cmd_valid && cmd_ready && !reset;
  assign w_is_read = (cmd_op == OP_READ_ROW) || (cmd_op == OP_READ_COL) ||
                     (cmd_op == OP_READ_DIAG);

  // Wrapped diagonal p: element i lives at column (p-i) mod WIDTH, in addr2 once it wraps.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_dcol[i] = cmd_param - PW'(i);
      w_dblk[i] = (PW'(i) <= cmd_param) ? cmd_addr1 : cmd_addr2;
    end
  end

  always_comb begin
    w_rd_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (cmd_op)
        OP_READ_ROW:  w_rd_vec[i] = r_blk[cmd_addr1][cmd_param][i];
        OP_READ_COL:  w_rd_vec[i] = r_blk[cmd_addr1][i][cmd_param];
        OP_READ_DIAG: w_rd_vec[i] = r_blk[w_dblk[i]][i][w_dcol[i]];
        default:      w_rd_vec[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_rd_valid <= w_accept && w_is_read;
      if (w_accept && w_is_read) r_data_out <= w_rd_vec;
    end
  end

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;

`ifdef MAT_CACHE_COPY_EN
  localparam logic [2:0] OP_COPY_T = 3'd7;
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COPY    = 1'b1;

  logic [0:0]    r_state;
  logic [PW-1:0] r_k;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic          r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && cmd_op == OP_COPY_T) begin
            if (cmd_addr1 != cmd_addr2) begin
              r_state <= S_COPY;
              r_k     <= '0;
              r_src   <= cmd_addr1;
              r_dst   <= cmd_addr2;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_COPY: begin
          if (r_k == PW'(WIDTH - 1)) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_done  <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_COPY);
  assign cmd_ready = !busy;
  assign done      = r_done;
`else
  assign busy      = 1'b0;
  assign cmd_ready = 1'b1;
  assign done      = 1'b0;
`endif

  // Storage is never reset; reset only stops an in-flight transpose.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      case (cmd_op)
        OP_WRITE_ROW:
          for (int j = 0; j < WIDTH; j++) r_blk[cmd_addr1][cmd_param][j] <= data_in[j];
        OP_WRITE_COL:
          for (int i = 0; i < WIDTH; i++) r_blk[cmd_addr1][i][cmd_param] <= data_in[i];
        OP_WRITE_DIAG:
          for (int i = 0; i < WIDTH; i++) r_blk[w_dblk[i]][i][w_dcol[i]] <= data_in[i];
        default: ;
      endcase
    end
`ifdef MAT_CACHE_COPY_EN
    if (!reset && r_state == S_COPY) begin
      for (int j = 0; j < WIDTH; j++) r_blk[r_dst][j][r_k] <= r_blk[r_src][r_k][j];
    end
`endif
  end

endmodule

// File: tb/tb_mat_tile_cache.sv
// Randomized bench for mat_tile_cache against a behavioural matrix model.
// Directed scenarios for COPY_T follow the MAT_CACHE_COPY_EN setting of the build.
module tb_mat_tile_cache;
  localparam int W  = 4;
  localparam int DW = 32;
  localparam int CS = 4;
  localparam int AW = 2;
  localparam int PW = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_op;
  logic [AW-1:0]          cmd_addr1;
  logic [AW-1:0]          cmd_addr2;
  logic [PW-1:0]          cmd_param;
  logic [W-1:0][DW-1:0]   data_in;
  logic [W-1:0][DW-1:0]   data_out;
  logic                   rd_valid;
  logic                   busy;
  logic                   done;

  always #5 clock = ~clock;

  mat_tile_cache #(.WIDTH(W), .DATA_W(DW), .CACHE_SIZE(CS)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2),
    .cmd_param(cmd_param), .data_in(data_in), .data_out(data_out),
    .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  // Behavioural model: plain matrix array plus the copy in flight.
  logic [DW-1:0]        m [CS][W][W];
  bit                   m_copying;
  int                   m_k, m_src, m_dst;
  logic                 e_rv, e_done;
  logic [W-1:0][DW-1:0] e_dout;
  bit                   chk_en = 0;
  int                   n_checks = 0;
  int                   n_pass = 0;

  task automatic chk(input string nm, input logic [W*DW-1:0] act, input logic [W*DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Element i of a row(1)/column(2)/diagonal(3) access maps to m[b][r][c].
  task automatic pos(input int kind, input int i, input int ad1, input int ad2, input int pp,
                     output int b, output int r, output int c);
    b = ad1; r = i; c = 0;
    case (kind)
      1: begin r = pp; c = i; end
      2: begin r = i; c = pp; end
      default: begin
        if (i <= pp) begin b = ad1; c = pp - i; end
        else begin b = ad2; c = W + pp - i; end
      end
    endcase
  endtask

  task automatic model_edge();
    int b, r, c;
    if (reset) begin
      m_copying = 0; m_k = 0; e_done = 0; e_rv = 0; e_dout = '0;
      return;
    end
    e_done = 0; e_rv = 0;
    if (m_copying) begin
      for (int j = 0; j < W; j++) m[m_dst][j][m_k] = m[m_src][m_k][j];
      if (m_k == W - 1) begin m_copying = 0; e_done = 1; end
      else m_k++;
    end else if (cmd_valid) begin
      case (int'(cmd_op))
        1, 2, 3: for (int i = 0; i < W; i++) begin
          pos(int'(cmd_op), i, int'(cmd_addr1), int'(cmd_addr2), int'(cmd_param), b, r, c);
          m[b][r][c] = data_in[i];
        end
        4, 5, 6: begin
          for (int i = 0; i < W; i++) begin
            pos(int'(cmd_op) - 3, i, int'(cmd_addr1), int'(cmd_addr2), int'(cmd_param), b, r, c);
            e_dout[i] = m[b][r][c];
          end
          e_rv = 1;
        end
`ifdef MAT_CACHE_COPY_EN
        7: begin
          if (cmd_addr1 != cmd_addr2) begin
            m_copying = 1; m_k = 0; m_src = int'(cmd_addr1); m_dst = int'(cmd_addr2);
          end else e_done = 1;
        end
`endif
        default: ;
      endcase
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, !m_copying);
      chk("busy", busy, m_copying);
      chk("done", done, e_done);
      chk("rd_valid", rd_valid, e_rv);
      chk("data_out", data_out, e_dout);
    end
  end

  task automatic step(input logic rst, input logic v, input logic [2:0] op, input int ad1,
                      input int ad2, input int pp, input logic [W-1:0][DW-1:0] d);
    reset = rst; cmd_valid = v; cmd_op = op;
    cmd_addr1 = ad1[AW-1:0]; cmd_addr2 = ad2[AW-1:0]; cmd_param = pp[PW-1:0]; data_in = d;
    @(posedge clock);
    #1;
    model_edge();
    chk_en = 1;
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 3'd0, 0, 0, 0, '0);
  endtask

  logic [W-1:0][DW-1:0] d, ev;
  int busy_cnt, done_cnt;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr1 = '0; cmd_addr2 = '0;
    cmd_param = '0; data_in = '0;
    step(1'b1, 1'b1, 3'd1, 0, 0, 0, '1);
    step(1'b1, 1'b0, 3'd0, 0, 0, 0, '0);
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_dout", data_out, '0);
    chk("reset_busy", busy, 1'b0);

    for (int b = 0; b < CS; b++)
      for (int r = 0; r < W; r++) begin
        for (int j = 0; j < W; j++) d[j] = $urandom;
        step(1'b0, 1'b1, 3'd1, b, 0, r, d);
      end

    for (int j = 0; j < W; j++) d[j] = DW'(j + 1);
    step(1'b0, 1'b1, 3'd1, 0, 0, 2, d);
    step(1'b0, 1'b1, 3'd5, 0, 0, 3, '0);
    chk("rowcol_rd_valid", rd_valid, 1'b1);
    chk("rowcol_elem2", data_out[2], 32'd4);

    for (int j = 0; j < W; j++) d[j] = DW'(10 + j);
    step(1'b0, 1'b1, 3'd3, 1, 2, 1, d);
    step(1'b0, 1'b1, 3'd6, 1, 2, 1, '0);
    chk("diag_readback", data_out, {32'd13, 32'd12, 32'd11, 32'd10});
    step(1'b0, 1'b1, 3'd4, 1, 0, 0, '0);
    chk("diag_blk1_0_1", data_out[1], 32'd10);
    step(1'b0, 1'b1, 3'd4, 2, 0, 2, '0);
    chk("diag_blk2_2_3", data_out[3], 32'd12);

    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) d[j] = DW'(4 * i + j);
      step(1'b0, 1'b1, 3'd1, 0, 0, i, d);
      for (int j = 0; j < W; j++) d[j] = DW'(100 + 4 * i + j);
      step(1'b0, 1'b1, 3'd1, 3, 0, i, d);
    end

`ifdef MAT_CACHE_COPY_EN
    busy_cnt = 0; done_cnt = 0;
    step(1'b0, 1'b1, 3'd7, 0, 3, 0, '0);
    for (int t = 0; t < 8; t++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (busy && cmd_ready) chk("copy_ready_low", cmd_ready, 1'b0);
      step(1'b0, 1'b1, 3'd4, 2, 0, 0, '0);
    end
    chk("copy_busy_cycles", busy_cnt, 4);
    chk("copy_done_pulses", done_cnt, 1);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, 3'd4, 3, 0, i, '0);
      for (int j = 0; j < W; j++) ev[j] = DW'(4 * j + i);
      chk("copy_transposed_row", data_out, ev);
    end

    step(1'b0, 1'b1, 3'd7, 1, 1, 0, '0);
    chk("self_copy_busy", busy, 1'b0);
    chk("self_copy_done", done, 1'b1);
    nop();
    chk("self_copy_done_end", done, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 3'd4, 1, 0, i, '0);

    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) d[j] = DW'(100 + 4 * i + j);
      step(1'b0, 1'b1, 3'd1, 3, 0, i, d);
    end
    step(1'b0, 1'b1, 3'd7, 0, 3, 0, '0);
    nop();
    nop();
    step(1'b1, 1'b0, 3'd0, 0, 0, 0, '0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rd_valid", rd_valid, 1'b0);
    chk("abort_dout", data_out, '0);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, 3'd4, 3, 0, i, '0);
      for (int j = 0; j < W; j++) ev[j] = (j < 2) ? DW'(4 * j + i) : DW'(100 + 4 * i + j);
      chk("abort_partial_row", data_out, ev);
    end
`else
    step(1'b0, 1'b1, 3'd7, 0, 3, 0, '0);
    chk("copy_off_busy", busy, 1'b0);
    chk("copy_off_done", done, 1'b0);
    nop();
    chk("copy_off_done_later", done, 1'b0);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, 3'd4, 3, 0, i, '0);
      for (int j = 0; j < W; j++) ev[j] = DW'(100 + 4 * i + j);
      chk("copy_off_blk3_row", data_out, ev);
    end
`endif

    for (int t = 0; t < 400; t++) begin
      for (int j = 0; j < W; j++) d[j] = $urandom;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), $urandom_range(0, CS - 1), $urandom_range(0, CS - 1),
           $urandom_range(0, W - 1), d);
    end
    for (int t = 0; t < 6; t++) nop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
